// File: rtl/int_ex_unit.sv
// rtl/int_ex_unit.sv - RV32I integer execution unit: issue-queue consumer, CDB producer
// Define INT_EX_MUL_EN to add the multi-cycle MUL/MULH/MULHSU/MULHU path.
module int_ex_unit #(
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 6,
    parameter int MUL_LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [DATA_W-1:0] issue_rs1_data,
    input  logic [DATA_W-1:0] issue_rs2_data,
    input  logic [DATA_W-1:0] issue_imm,
    input  logic [DATA_W-1:0] issue_pc,
    input  logic [6:0]        issue_opcode,
    input  logic [2:0]        issue_funct3,
    input  logic [6:0]        issue_funct7,
    input  logic [TAG_W-1:0]  issue_tag,
    output logic              ex_busy,
    output logic              ex_done,
    output logic              cdb_req,
    input  logic              cdb_gnt,
    output logic              cdb_valid,
    output logic [DATA_W-1:0] cdb_data,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic              cdb_branch,
    output logic              cdb_branch_taken,
    output logic              cdb_jalr,
    output logic [DATA_W-1:0] jalr_target
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

`ifdef INT_EX_MUL_EN
    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BCAST, S_MUL} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BCAST} state_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] res_q, res_d, jt_q, jt_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              br_q, br_d, tk_q, tk_d, jl_q, jl_d;
    logic              busy_q, busy_d, done_q, done_d, req_q, req_d, valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d, ojt_q, ojt_d;
    logic [TAG_W-1:0]  otag_q, otag_d;
    logic              obr_q, obr_d, otk_q, otk_d, ojl_q, ojl_d;

    logic [DATA_W-1:0] op_b, alu_res, iss_res, jsum;
    logic [4:0]        shamt;
    logic              iss_br, iss_jl, br_taken, bcast;

`ifdef INT_EX_MUL_EN
    logic [DATA_W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_res;
    logic [1:0]          mf3_q, mf3_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W:0]     mul_a_ext, mul_b_ext;
    logic [2*DATA_W-1:0] prod;
    logic                go_mul;

    // One extension bit per operand selects signed vs unsigned for the MULH variants.
    always_comb begin
        mul_a_ext = {(mf3_q != 2'b11) & mul_a_q[DATA_W-1], mul_a_q};
        mul_b_ext = {~mf3_q[1] & mul_b_q[DATA_W-1], mul_b_q};
        prod      = (2*DATA_W)'($signed(mul_a_ext) * $signed(mul_b_ext));
        mul_res   = (mf3_q == 2'b00) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
    end
`endif

    always_comb begin
        op_b  = (issue_opcode == OP_R) ? issue_rs2_data : issue_imm;
        shamt = op_b[4:0];
        case (issue_funct3)
            3'b000:  alu_res = ((issue_opcode == OP_R) && issue_funct7[5]) ?
                               issue_rs1_data - op_b : issue_rs1_data + op_b;
            3'b001:  alu_res = issue_rs1_data << shamt;
            3'b010:  alu_res = {{(DATA_W-1){1'b0}}, $signed(issue_rs1_data) < $signed(op_b)};
            3'b011:  alu_res = {{(DATA_W-1){1'b0}}, issue_rs1_data < op_b};
            3'b100:  alu_res = issue_rs1_data ^ op_b;
            3'b101:  alu_res = issue_funct7[5] ? DATA_W'($signed(issue_rs1_data) >>> shamt)
                                               : issue_rs1_data >> shamt;
            3'b110:  alu_res = issue_rs1_data | op_b;
            default: alu_res = issue_rs1_data & op_b;
        endcase

        case (issue_funct3)
            3'b000:  br_taken = issue_rs1_data == issue_rs2_data;
            3'b001:  br_taken = issue_rs1_data != issue_rs2_data;
            3'b100:  br_taken = $signed(issue_rs1_data) < $signed(issue_rs2_data);
            3'b101:  br_taken = $signed(issue_rs1_data) >= $signed(issue_rs2_data);
            3'b110:  br_taken = issue_rs1_data < issue_rs2_data;
            3'b111:  br_taken = issue_rs1_data >= issue_rs2_data;
            default: br_taken = 1'b0;
        endcase

        jsum    = issue_rs1_data + issue_imm;
        iss_res = '0;
        iss_br  = 1'b0;
        iss_jl  = 1'b0;
`ifdef INT_EX_MUL_EN
        go_mul  = 1'b0;
`endif
        case (issue_opcode)
            OP_R: begin
                if (issue_funct7 == 7'b0000001) begin
`ifdef INT_EX_MUL_EN
                    go_mul = ~issue_funct3[2];
`endif
                end else begin
                    iss_res = alu_res;
                end
            end
            OP_I:     iss_res = alu_res;
            OP_LUI:   iss_res = issue_imm;
            OP_AUIPC: iss_res = issue_pc + issue_imm;
            OP_JAL:   iss_res = issue_pc + DATA_W'(4);
            OP_JALR: begin
                iss_res = issue_pc + DATA_W'(4);
                iss_jl  = 1'b1;
            end
            OP_BR: begin
                iss_res = issue_pc + issue_imm;
                iss_br  = 1'b1;
            end
            default:  iss_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        tag_d   = tag_q;
        br_d    = br_q;
        tk_d    = tk_q;
        jl_d    = jl_q;
        jt_d    = jt_q;
`ifdef INT_EX_MUL_EN
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        mf3_d   = mf3_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (issue_valid) begin
                    tag_d   = issue_tag;
                    res_d   = iss_res;
                    br_d    = iss_br;
                    tk_d    = iss_br & br_taken;
                    jl_d    = iss_jl;
                    jt_d    = {jsum[DATA_W-1:1], 1'b0};
                    state_d = S_REQ;
`ifdef INT_EX_MUL_EN
                    if (go_mul) begin
                        mul_a_d = issue_rs1_data;
                        mul_b_d = issue_rs2_data;
                        mf3_d   = issue_funct3[1:0];
                        cnt_d   = CNT_W'(MUL_LATENCY - 1);
                        state_d = S_MUL;
                    end
`endif
                end
            end
`ifdef INT_EX_MUL_EN
            S_MUL: begin
                if (cnt_q == '0) begin
                    res_d   = mul_res;
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            S_REQ:   if (cdb_gnt) state_d = S_BCAST;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        bcast   = (state_d == S_BCAST);
        busy_d  = (state_d != S_IDLE);
        req_d   = (state_d == S_REQ);
        valid_d = bcast;
        done_d  = bcast;
        data_d  = bcast ? res_d : '0;
        otag_d  = bcast ? tag_d : '0;
        obr_d   = bcast & br_d;
        otk_d   = bcast & tk_d;
        ojl_d   = bcast & jl_d;
        ojt_d   = bcast ? jt_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            tag_q   <= '0;
            br_q    <= 1'b0;
            tk_q    <= 1'b0;
            jl_q    <= 1'b0;
            jt_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            otag_q  <= '0;
            obr_q   <= 1'b0;
            otk_q   <= 1'b0;
            ojl_q   <= 1'b0;
            ojt_q   <= '0;
`ifdef INT_EX_MUL_EN
            mul_a_q <= '0;
            mul_b_q <= '0;
            mf3_q   <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
            br_q    <= br_d;
            tk_q    <= tk_d;
            jl_q    <= jl_d;
            jt_q    <= jt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            otag_q  <= otag_d;
            obr_q   <= obr_d;
            otk_q   <= otk_d;
            ojl_q   <= ojl_d;
            ojt_q   <= ojt_d;
`ifdef INT_EX_MUL_EN
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            mf3_q   <= mf3_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign ex_busy          = busy_q;
    assign ex_done          = done_q;
    assign cdb_req          = req_q;
    assign cdb_valid        = valid_q;
    assign cdb_data         = data_q;
    assign cdb_tag          = otag_q;
    assign cdb_branch       = obr_q;
    assign cdb_branch_taken = otk_q;
    assign cdb_jalr         = ojl_q;
    assign jalr_target      = ojt_q;
endmodule

// File: tb/tb_int_ex_unit.sv
// tb/tb_int_ex_unit.sv - directed and randomized checks of int_ex_unit against a reference model
module tb_int_ex_unit;
    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [31:0] issue_rs1_data, issue_rs2_data, issue_imm, issue_pc;
    logic [6:0]  issue_opcode, issue_funct7;
    logic [2:0]  issue_funct3;
    logic [5:0]  issue_tag;
    logic        ex_busy, ex_done, cdb_req, cdb_gnt, cdb_valid;
    logic [31:0] cdb_data, jalr_target;
    logic [5:0]  cdb_tag;
    logic        cdb_branch, cdb_branch_taken, cdb_jalr;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    int_ex_unit #(.DATA_W(32), .TAG_W(6), .MUL_LATENCY(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_opcode(issue_opcode),
        .issue_funct3(issue_funct3), .issue_funct7(issue_funct7), .issue_tag(issue_tag),
        .ex_busy(ex_busy), .ex_done(ex_done), .cdb_req(cdb_req), .cdb_gnt(cdb_gnt),
        .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_tag(cdb_tag),
        .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken),
        .cdb_jalr(cdb_jalr), .jalr_target(jalr_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ctl();
        return {60'd0, ex_busy, cdb_req, cdb_valid, ex_done};
    endfunction

    function automatic logic [63:0] quiet();
        return {cdb_branch, cdb_branch_taken, cdb_jalr, cdb_tag, cdb_data, jalr_target != 32'd0};
    endfunction

    // Reference model: RV32I(+M) semantics in plain arithmetic.
    function automatic void model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                  input logic [31:0] pc, output logic [31:0] data, output logic br,
                                  output logic tk, output logic jl, output int lat);
        logic [31:0] y;
        longint      p;
        data = 32'd0; br = 1'b0; tk = 1'b0; jl = 1'b0; lat = 0; p = 0;
        if (op == 7'h33 || op == 7'h13) begin
            y = (op == 7'h33) ? b : imm;
            if (op == 7'h33 && f7 == 7'h01) begin
`ifdef INT_EX_MUL_EN
                if (!f3[2]) begin
                    lat = MUL_LAT;
                    case (f3[1:0])
                        2'd0, 2'd1: p = longint'($signed(a)) * longint'($signed(b));
                        2'd2:       p = longint'($signed(a)) * longint'({32'd0, b});
                        default:    p = longint'({32'd0, a}) * longint'({32'd0, b});
                    endcase
                    data = (f3[1:0] == 2'd0) ? p[31:0] : p[63:32];
                end
`endif
            end else begin
                case (f3)
                    3'd0: data = (op == 7'h33 && f7[5]) ? a - y : a + y;
                    3'd1: data = a << y[4:0];
                    3'd2: data = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
                    3'd3: data = (a < y) ? 32'd1 : 32'd0;
                    3'd4: data = a ^ y;
                    3'd5: data = (f7[5] && a[31]) ? ~((~a) >> y[4:0]) : a >> y[4:0];
                    3'd6: data = a | y;
                    default: data = a & y;
                endcase
            end
        end else begin
            case (op)
                7'h37: data = imm;
                7'h17: data = pc + imm;
                7'h6F: data = pc + 32'd4;
                7'h67: begin data = pc + 32'd4; jl = 1'b1; end
                7'h63: begin
                    data = pc + imm;
                    br   = 1'b1;
                    case (f3)
                        3'd0: tk = (a == b);
                        3'd1: tk = (a != b);
                        3'd4: tk = ($signed(a) < $signed(b));
                        3'd5: tk = !($signed(a) < $signed(b));
                        3'd6: tk = (a < b);
                        3'd7: tk = !(a < b);
                        default: tk = 1'b0;
                    endcase
                end
                default: data = 32'd0;
            endcase
        end
    endfunction

    // Issues one op and follows it cycle by cycle; g = REQ cycles with grant held low.
    task automatic run_op(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [5:0] tag,
                          input int g);
        logic [31:0] e_data;
        logic        e_br, e_tk, e_jl;
        int          lat;
        model(op, f3, f7, a, b, imm, pc, e_data, e_br, e_tk, e_jl, lat);
        @(negedge clk);
        issue_opcode = op; issue_funct3 = f3; issue_funct7 = f7;
        issue_rs1_data = a; issue_rs2_data = b; issue_imm = imm; issue_pc = pc;
        issue_tag = tag; issue_valid = 1'b1; cdb_gnt = (g == 0);
        @(negedge clk);
        issue_valid = 1'b0;
        issue_rs1_data = $urandom; issue_rs2_data = $urandom; issue_tag = 6'($urandom);
        for (int i = 0; i < lat; i++) begin
            check({name, " mul_phase"}, ctl(), 64'b1000);
            @(negedge clk);
        end
        for (int i = 0; i <= g; i++) begin
            check({name, " req_phase"}, ctl(), 64'b1100);
            cdb_gnt = (i == g);
            @(negedge clk);
        end
        check({name, " bcast_ctl"}, ctl(), 64'b1011);
        check({name, " data"}, {32'd0, cdb_data}, {32'd0, e_data});
        check({name, " tag"}, {58'd0, cdb_tag}, {58'd0, tag});
        check({name, " br_tk_jl"}, {61'd0, cdb_branch, cdb_branch_taken, cdb_jalr},
              {61'd0, e_br, e_tk, e_jl});
        if (e_jl) check({name, " jalr_target"}, {32'd0, jalr_target}, {32'd0, (a + imm) & 32'hFFFF_FFFE});
        cdb_gnt = 1'b0;
        @(negedge clk);
        check({name, " after_ctl"}, ctl(), 64'b0000);
        check({name, " after_fields"}, quiet(), 64'd0);
    endtask

    initial begin
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          dones;

        rst = 1'b1; issue_valid = 1'b0; cdb_gnt = 1'b0;
        issue_rs1_data = '0; issue_rs2_data = '0; issue_imm = '0; issue_pc = '0;
        issue_opcode = '0; issue_funct3 = '0; issue_funct7 = '0; issue_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", ctl(), 64'd0);
        check("reset_fields", quiet(), 64'd0);
        rst = 1'b0;

        run_op("add", 7'h33, 3'd0, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0, 6'd9, 0);
        run_op("sub_stall", 7'h33, 3'd0, 7'h20, 32'd3, 32'd5, 32'd0, 32'd0, 6'd2, 4);
        run_op("blt", 7'h63, 3'd4, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 6'd5, 1);
        run_op("bltu", 7'h63, 3'd6, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 6'd6, 0);
        run_op("jalr", 7'h67, 3'd0, 7'h00, 32'h1001, 32'd0, 32'd4, 32'h40, 6'd7, 0);
        run_op("mulhu", 7'h33, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 6'd8, 0);
        run_op("mul_div_slot", 7'h33, 3'd4, 7'h01, 32'd10, 32'd3, 32'd0, 32'd0, 6'd10, 0);
        run_op("srai", 7'h13, 3'd5, 7'h20, 32'h8000_0010, 32'd0, 32'd4, 32'd0, 6'd11, 2);
        run_op("unknown", 7'h03, 3'd2, 7'h00, 32'd1, 32'd2, 32'd3, 32'd4, 6'd12, 0);

        // Hold issue_valid across BCAST, then reset while the second op waits in REQ.
        dones = 0;
        @(negedge clk);
        issue_opcode = 7'h33; issue_funct3 = 3'd0; issue_funct7 = 7'h00;
        issue_rs1_data = 32'd1; issue_rs2_data = 32'd1; issue_tag = 6'd3;
        issue_valid = 1'b1; cdb_gnt = 1'b1;
        @(negedge clk);
        check("rst_seq op1_req", ctl(), 64'b1100);
        @(negedge clk);
        check("rst_seq op1_bcast", ctl(), 64'b1011);
        if (ex_done) dones++;
        issue_tag = 6'd4; cdb_gnt = 1'b0;
        @(negedge clk);
        check("rst_seq idle_after_bcast", ctl(), 64'b0000);
        if (ex_done) dones++;
        @(negedge clk);
        check("rst_seq op2_req", ctl(), 64'b1100);
        rst = 1'b1; issue_valid = 1'b0;
        @(negedge clk);
        check("rst_seq reset_ctl", ctl(), 64'd0);
        check("rst_seq reset_fields", quiet(), 64'd0);
        rst = 1'b0; cdb_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ex_done || cdb_valid) dones++;
        end
        check("rst_seq done_count", 64'(dones), 64'd1);
        cdb_gnt = 1'b0;

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0: op = 7'h33;
                1: op = 7'h13;
                2: op = 7'h37;
                3: op = 7'h17;
                4: op = 7'h6F;
                5: op = 7'h67;
                6: op = 7'h63;
                default: op = 7'h0F;
            endcase
            case ($urandom_range(0, 2))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = 7'h01;
            endcase
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_op("random", op, f3, f7, a, b, $urandom, $urandom, 6'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
